// File: rtl/io_hex_pkg.sv
// rtl/io_hex_pkg.sv - segment codes, FSM states and limits shared by io_hex_display
package io_hex_pkg;

    localparam int          NUM_DIGITS = 6;
    localparam logic [31:0] BCD_MAX    = 32'd999999;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    // Non-decimal nibbles cannot leave the converter; show a dash if one ever does.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/io_hex_display_if.sv
// rtl/io_hex_display_if.sv - CPU out-port write path into the hex display
interface io_hex_display_if;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        busy;

    modport master (output wr_en, output wr_data, input  busy);
    modport slave  (input  wr_en, input  wr_data, output busy);
endinterface

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - one BCD digit plus blank flag to active-low segments
module seg7_encode
    import io_hex_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);
    assign seg = blank ? SEG_BLANK : seg_code(digit);
endmodule

// File: rtl/io_hex_display.sv
// rtl/io_hex_display.sv - out-port value to six 7-seg digits via double-dabble
// IO_HEX_BLANK_EN: blank leading zeros (hex0 always shows a digit).
module io_hex_display #(
    parameter int NUM_DIGITS = io_hex_pkg::NUM_DIGITS,
    parameter int CONV_W     = 20
) (
    input  logic             clock,
    input  logic             reset,
    io_hex_display_if.slave  bus,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [6:0]       hex4,
    output logic [6:0]       hex5
);
    import io_hex_pkg::*;

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(CONV_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_W - 1);
`ifdef IO_HEX_BLANK_EN
    localparam logic [6:0] SEG_RST_HI = SEG_BLANK;
`else
    localparam logic [6:0] SEG_RST_HI = SEG_0;
`endif

    state_t            state;
    logic              busy_r;
    logic              ovf;
    logic              pend_valid;
    logic [31:0]       pend_data;
    logic [BCD_W-1:0]  bcd;
    logic [BCD_W-1:0]  bcd_adj;
    logic [CONV_W-1:0] bin;
    logic [CNT_W-1:0]  cnt;
    logic [NUM_DIGITS-1:0] blank;
    logic [6:0]        enc   [NUM_DIGITS];
    logic [6:0]        hex_r [NUM_DIGITS];
    logic              go;
    logic              go_ovf;
    logic [31:0]       go_data;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        logic lead;
        lead  = 1'b1;
        blank = '0;
`ifdef IO_HEX_BLANK_EN
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lead     = lead & (bcd[4*i +: 4] == 4'd0);
            blank[i] = lead;
        end
`endif
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
        seg7_encode u_enc (
            .digit (bcd[4*g +: 4]),
            .blank (blank[g]),
            .seg   (enc[g])
        );
    end

    // A write landing in the LOAD cycle itself is newer than the pending slot.
    always_comb begin
        go      = 1'b0;
        go_data = bus.wr_data;
        if (state == IDLE) begin
            go = bus.wr_en;
        end else if (state == LOAD) begin
            go      = bus.wr_en | pend_valid;
            go_data = bus.wr_en ? bus.wr_data : pend_data;
        end
        go_ovf = (go_data > BCD_MAX);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            busy_r     <= 1'b0;
            ovf        <= 1'b0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            bcd        <= '0;
            bin        <= '0;
            cnt        <= '0;
            for (int i = 0; i < NUM_DIGITS; i++)
                hex_r[i] <= (i == 0) ? SEG_0 : SEG_RST_HI;
        end else begin
            case (state)
                CONV: begin
                    if (bus.wr_en) begin
                        pend_valid <= 1'b1;
                        pend_data  <= bus.wr_data;
                    end
                    bcd <= {bcd_adj[BCD_W-2:0], bin[CONV_W-1]};
                    bin <= {bin[CONV_W-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST)
                        state <= LOAD;
                end
                LOAD: begin
                    for (int i = 0; i < NUM_DIGITS; i++)
                        hex_r[i] <= ovf ? SEG_DASH : enc[i];
                    pend_valid <= 1'b0;
                    if (!go) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (go) begin
                ovf    <= go_ovf;
                busy_r <= 1'b1;
                if (go_ovf) begin
                    state <= LOAD;
                end else begin
                    state <= CONV;
                    bcd   <= '0;
                    bin   <= go_data[CONV_W-1:0];
                    cnt   <= '0;
                end
            end
        end
    end

    assign bus.busy = busy_r;
    assign hex0 = hex_r[0];
    assign hex1 = hex_r[1];
    assign hex2 = hex_r[2];
    assign hex3 = hex_r[3];
    assign hex4 = hex_r[4];
    assign hex5 = hex_r[5];

endmodule

// File: tb/tb_io_hex_display.sv
// tb/tb_io_hex_display.sv - scoreboard bench for io_hex_display (honours IO_HEX_BLANK_EN)
module tb_io_hex_display;

`ifdef IO_HEX_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif
    localparam logic [6:0]  S0      = 7'b1000000;
    localparam logic [6:0]  S_BLANK = 7'b1111111;
    localparam logic [41:0] RST_PAT = BLANK ? {{5{S_BLANK}}, S0} : {6{S0}};

    logic clock = 1'b0;
    logic reset;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [41:0] hex_all;
    int ecnt = 0;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;
    always @(posedge clock) ecnt <= ecnt + 1;

    io_hex_display_if bus ();

    io_hex_display dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .hex0  (hex0),
        .hex1  (hex1),
        .hex2  (hex2),
        .hex3  (hex3),
        .hex4  (hex4),
        .hex5  (hex5)
    );

    assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

    typedef struct {
        int          due;
        logic [41:0] exp;
        string       tag;
    } exp_t;
    exp_t sb[$];
    exp_t cur;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [41:0] model(input logic [31:0] v);
        logic [41:0] r;
        int p;
        int d;
        bit lead;
        if (v > 32'd999999) return {6{7'b0111111}};
        r    = '0;
        p    = 100000;
        lead = 1'b1;
        for (int i = 5; i >= 0; i--) begin
            d = int'(v / p) % 10;
            p = p / 10;
            if (d != 0 || i == 0) lead = 1'b0;
            r[i*7 +: 7] = (lead && BLANK) ? S_BLANK : seg(d);
        end
        return r;
    endfunction

    always @(negedge clock) begin
        if (sb.size() > 0 && sb[0].due == ecnt) begin
            cur = sb.pop_front();
            chk(cur.tag, {22'h0, hex_all}, {22'h0, cur.exp});
        end
    end

    task automatic push(input string tag, input int due, input logic [31:0] v);
        exp_t e;
        e.due = due;
        e.exp = model(v);
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Called at a negedge; strobe is sampled on the next rising edge (returned as e).
    task automatic wr(input logic [31:0] v, output int e);
        bus.wr_data = v;
        bus.wr_en   = 1'b1;
        e = ecnt + 1;
        @(negedge clock);
        bus.wr_en = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at edge %0d", ecnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e2, e3, n;
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", {63'h0, bus.busy}, 64'd0);
        chk("rst_hex", {22'h0, hex_all}, {22'h0, RST_PAT});
        reset = 1'b0;
        @(negedge clock);

        wr(32'd6, e);
        push("val6", e + 21, 32'd6);
        drain();
        chk("val6_hex0", {57'h0, hex0}, {57'h0, 7'b0000010});

        wr(32'd123456, e);
        push("val123456", e + 21, 32'd123456);
        busy_len(n);
        chk("busy_123456", 64'(n), 64'd21);
        drain();
        chk("val123456_lit", {22'h0, hex_all},
            {22'h0, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010});

        wr(32'd999999, e);
        push("val999999", e + 21, 32'd999999);
        drain();

        wr(32'd1000000, e);
        push("ovf_1000000", e + 1, 32'd1000000);
        busy_len(n);
        chk("busy_ovf", 64'(n), 64'd1);
        drain();

        wr(32'd42, e);
        push("val42", e + 21, 32'd42);
        drain();
        wr(32'h0010_0005, e);
        push("ovf_bit20", e + 1, 32'h0010_0005);
        drain();

        wr(32'd5, e);
        push("pend_first5", e + 21, 32'd5);
        wr(32'd7, e2);
        wr(32'd9, e3);
        push("pend_last9", e + 42, 32'd9);
        busy_len(n);
        chk("busy_pend", 64'(n), 64'd40);
        drain();

        wr(32'd777777, e);
        while (ecnt < e + 9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midconv_rst_busy", {63'h0, bus.busy}, 64'd0);
        chk("midconv_rst_hex", {22'h0, hex_all}, {22'h0, RST_PAT});
        repeat (25) @(negedge clock);
        chk("abort_no_load", {22'h0, hex_all}, {22'h0, RST_PAT});

        wr(32'd0, e);
        push("val0", e + 21, 32'd0);
        drain();
        chk("val0_hex0", {57'h0, hex0}, {57'h0, S0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
